// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared sizes, FSM state type and word-unpacking helper for
//               the 4x4 matrix-multiply engine.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int OUT_W  = 32;
  localparam int WORD_W = N * DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Element idx of a packed memory word occupies bits [16*idx+15 : 16*idx].
  function automatic logic [DATA_W-1:0] get_elem(input logic [WORD_W-1:0] word,
                                                 input int idx);
    return word[idx*DATA_W +: DATA_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_512x64.sv
`default_nettype none
// ============================================================================
// Module      : ram_512x64
// Description : Single-port synchronous RAM, one-cycle read latency.
//               Contents are never cleared; only the read register resets.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_512x64 #(
  parameter int WIDTH = 64,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] ram [2**AW];
  logic [WIDTH-1:0] rdata_q;

  // Write port: storage array has no reset.
  always_ff @(posedge clk) begin
    if (we_i) ram[addr_i] <= wdata_i;
  end

  // Registered read data, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= ram[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/matrix_mult_4x4.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mult_4x4
// Description : 4x4 unsigned matrix multiply. Operands live in two 512x64
//               RAMs (A by column, B by row); a skewed 4x4 systolic MAC array
//               accumulates C = A*B, readable one element at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_mult_4x4
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_writing_to_mem,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [WORD_W-1:0] data_pi,
  input  logic [ADDR_W-1:0] addr_pi,
  input  logic              start_mat_mul,
  output logic              done_mat_mul,
  input  logic [ADDR_W-1:0] out_sel,
  output logic [OUT_W-1:0]  data_out
);

  // Word k arrives at the array edge two cycles after start is accepted; the
  // far corner PE sees its last pair 3*(N-1) cycles after that.
  localparam logic [3:0] c_LOAD_LAST = 4'(N - 1);
  localparam logic [3:0] c_RUN_LAST  = 4'(3 * N - 2);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_valid_q;
  logic              w_start_acc;
  logic              w_mem_rd;
  logic              w_acc_en;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WORD_W-1:0] w_rdata_a, w_rdata_b;

  logic [DATA_W-1:0] w_a_left [N];
  logic [DATA_W-1:0] w_b_top  [N];
  logic [DATA_W-1:0] w_a_out  [N][N];
  logic [DATA_W-1:0] w_b_out  [N][N];
  logic [OUT_W-1:0]  w_acc    [N*N];

  // A start request only counts while the engine owns the memories.
  assign w_start_acc = (state_q == IDLE) && start_mat_mul && !enable_writing_to_mem;

  // State and run-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_start_acc) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == c_LOAD_LAST) state_d = COMPUTE;
      end
      COMPUTE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == c_RUN_LAST) state_d = DONE;
      end
      DONE: begin
        if (!start_mat_mul) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    done_mat_mul = 1'b0;
    w_mem_rd     = 1'b0;
    w_acc_en     = 1'b0;
    case (state_q)
      LOAD:    begin w_mem_rd = 1'b1; w_acc_en = 1'b1; end
      COMPUTE: w_acc_en = 1'b1;
      DONE:    done_mat_mul = 1'b1;
      default: ;
    endcase
  end

  // Marks the cycles in which the RAM outputs hold operand words 0..3.
  always_ff @(posedge clk) begin
    if (reset) rd_valid_q <= 1'b0;
    else       rd_valid_q <= w_mem_rd;
  end

  // Host address while it owns the port, otherwise the engine's word index.
  assign w_mem_addr = enable_writing_to_mem ? addr_pi : ADDR_W'(cnt_q[1:0]);

  ram_512x64 #(.WIDTH(WORD_W), .AW(ADDR_W)) matrix_A_u (
    .clk     (clk),
    .rst     (reset),
    .we_i    (enable_writing_to_mem && we_a),
    .re_i    (w_mem_rd && !enable_writing_to_mem),
    .addr_i  (w_mem_addr),
    .wdata_i (data_pi),
    .rdata_o (w_rdata_a)
  );

  ram_512x64 #(.WIDTH(WORD_W), .AW(ADDR_W)) matrix_B_u (
    .clk     (clk),
    .rst     (reset),
    .we_i    (enable_writing_to_mem && we_b),
    .re_i    (w_mem_rd && !enable_writing_to_mem),
    .addr_i  (w_mem_addr),
    .wdata_i (data_pi),
    .rdata_o (w_rdata_b)
  );

  // Row i of A is delayed by i cycles, zero outside valid read cycles.
  for (genvar gi = 0; gi < N; gi++) begin : g_a_skew
    logic [DATA_W-1:0] w_elem;
    assign w_elem = rd_valid_q ? get_elem(w_rdata_a, gi) : '0;
    if (gi == 0) begin : g_direct
      assign w_a_left[gi] = w_elem;
    end else begin : g_delay
      logic [DATA_W-1:0] sk_q [gi];
      // Shift chain flushed on reset and on every accepted start.
      always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
          for (int s = 0; s < gi; s++) sk_q[s] <= '0;
        end else begin
          sk_q[0] <= w_elem;
          for (int s = 1; s < gi; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign w_a_left[gi] = sk_q[gi-1];
    end
  end

  // Column j of B is delayed by j cycles, zero outside valid read cycles.
  for (genvar gj = 0; gj < N; gj++) begin : g_b_skew
    logic [DATA_W-1:0] w_elem;
    assign w_elem = rd_valid_q ? get_elem(w_rdata_b, gj) : '0;
    if (gj == 0) begin : g_direct
      assign w_b_top[gj] = w_elem;
    end else begin : g_delay
      logic [DATA_W-1:0] sk_q [gj];
      // Shift chain flushed on reset and on every accepted start.
      always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
          for (int s = 0; s < gj; s++) sk_q[s] <= '0;
        end else begin
          sk_q[0] <= w_elem;
          for (int s = 1; s < gj; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign w_b_top[gj] = sk_q[gj-1];
    end
  end

  // Systolic array: a moves right, b moves down, one register per PE.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DATA_W-1:0]   w_a_in, w_b_in;
      logic [DATA_W-1:0]   a_q, b_q;
      logic [2*DATA_W-1:0] w_prod;
      logic [OUT_W-1:0]    acc_q;

      if (gj == 0) begin : g_a_edge
        assign w_a_in = w_a_left[gi];
      end else begin : g_a_pass
        assign w_a_in = w_a_out[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign w_b_in = w_b_top[gj];
      end else begin : g_b_pass
        assign w_b_in = w_b_out[gi-1][gj];
      end

      assign w_prod = {{DATA_W{1'b0}}, w_a_in} * {{DATA_W{1'b0}}, w_b_in};

      // Pass-through registers and the wrapping accumulator, frozen outside a run.
      always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q <= w_a_in;
          b_q <= w_b_in;
          if (w_acc_en) acc_q <= acc_q + OUT_W'(w_prod);
        end
      end

      assign w_a_out[gi][gj]  = a_q;
      assign w_b_out[gi][gj]  = b_q;
      assign w_acc[gi*N + gj] = acc_q;
    end
  end

  // Result select: C[out_sel] for 0..15, zero above.
  always_comb begin
    data_out = '0;
    if (out_sel < ADDR_W'(N*N)) data_out = w_acc[out_sel[3:0]];
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_4x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_mult_4x4
// Description : Scoreboard bench for matrix_mult_4x4. Expected results come
//               from a plain matrix-product model over the bench's own A/B.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matrix_mult_4x4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        we_a = 1'b0;
  logic        we_b = 1'b0;
  logic [63:0] data_pi = '0;
  logic [8:0]  addr_pi = '0;
  logic        start = 1'b0;
  logic        done;
  logic [8:0]  out_sel = '0;
  logic [31:0] data_out;

  always #5 clk = ~clk;

  matrix_mult_4x4 dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable_writing_to_mem (en),
    .we_a                  (we_a),
    .we_b                  (we_b),
    .data_pi               (data_pi),
    .addr_pi               (addr_pi),
    .start_mat_mul         (start),
    .done_mat_mul          (done),
    .out_sel               (out_sel),
    .data_out              (data_out)
  );

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } rd_t;

  rd_t         exp_q[$];
  rd_t         mon_e;
  logic        rd_active = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  bit   [15:0] a_m [4][4];
  bit   [15:0] b_m [4][4];
  logic [31:0] c_plan [16] = '{98, 90, 82, 34, 75, 63, 51, 26,
                               62, 48, 44, 19, 54, 40, 46, 13};

  // Monitor: every cycle a read is presented, pop one expectation and compare.
  always @(negedge clk) begin
    if (rd_active) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected sel=%0d got=%h (no expectation queued)", out_sel, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (data_out !== mon_e.exp) begin
          n_err++;
          $display("FAIL rd_sel%0d got=%h exp=%h", mon_e.sel, data_out, mon_e.exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // C[i][j] = sum_k A[i][k]*B[k][j], modulo 2^32.
  function automatic logic [31:0] model_c(input int i, input int j);
    logic [31:0] s = '0;
    for (int k = 0; k < 4; k++) s += 32'(a_m[i][k]) * 32'(b_m[k][j]);
    return s;
  endfunction

  task automatic write_word(input bit is_b, input logic [8:0] addr, input logic [63:0] d);
    en = 1'b1; we_a = !is_b; we_b = is_b; addr_pi = addr; data_pi = d;
    tick();
    we_a = 1'b0; we_b = 1'b0;
  endtask

  // Pack A by column and B by row; also scribble on words the engine must skip.
  task automatic load_matrices();
    logic [63:0] wa, wb;
    for (int k = 0; k < 4; k++) begin
      for (int e = 0; e < 4; e++) begin
        wa[16*e +: 16] = a_m[e][k];
        wb[16*e +: 16] = b_m[k][e];
      end
      write_word(1'b0, 9'(k), wa);
      write_word(1'b1, 9'(k), wb);
    end
    write_word(1'b0, 9'd4,   {2{$urandom()}});
    write_word(1'b1, 9'd4,   {2{$urandom()}});
    write_word(1'b0, 9'd511, {2{$urandom()}});
    write_word(1'b1, 9'd511, {2{$urandom()}});
    en = 1'b0;
    tick();
  endtask

  task automatic set_from_words(input logic [63:0] aw [4], input logic [63:0] bw [4]);
    for (int k = 0; k < 4; k++)
      for (int e = 0; e < 4; e++) begin
        a_m[e][k] = aw[k][16*e +: 16];
        b_m[k][e] = bw[k][16*e +: 16];
      end
  endtask

  // Raise start and measure cycles until done; start is left high.
  task automatic run_start();
    int lat = 0;
    start = 1'b1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("done_latency", 32'(lat), 32'd12);
  endtask

  task automatic present(input int sel, input logic [31:0] exp);
    rd_t r;
    r.sel = sel; r.exp = exp;
    out_sel = 9'(sel);
    exp_q.push_back(r);
    rd_active = 1'b1;
    tick();
  endtask

  // mode 0: model, 1: plan constants, 2: zeros, 3: A itself, 4: constant fill.
  task automatic sweep(input int mode, input logic [31:0] fill);
    logic [31:0] e;
    for (int s = 0; s < 16; s++) begin
      case (mode)
        0:       e = model_c(s / 4, s % 4);
        1:       e = c_plan[s];
        2:       e = '0;
        3:       e = 32'(a_m[s / 4][s % 4]);
        default: e = fill;
      endcase
      present(s, e);
    end
    present(16, '0);
    present(511, '0);
    present(int'($urandom_range(510, 17)), '0);
    rd_active = 1'b0;
  endtask

  task automatic release_start();
    check("done_held", 32'(done), 32'd1);
    start = 1'b0;
    tick();
    check("done_fall", 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] aw [4];
    logic [63:0] bw [4];

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_done", 32'(done), 32'd0);
    sweep(2, '0);

    // Reference operands with hand-computed products.
    aw = '{64'h0009_0005_0003_0008, 64'h0001_0002_0003_0004,
           64'h0000_0001_0003_0006, 64'h0005_0006_0007_0008};
    bw = '{64'h0000_0003_0001_0001, 64'h0003_0004_0001_0000,
           64'h0001_0003_0005_0003, 64'h0002_0003_0006_0009};
    set_from_words(aw, bw);
    load_matrices();
    run_start();
    sweep(1, '0);
    release_start();
    sweep(1, '0);
    run_start();
    sweep(1, '0);
    release_start();

    // Start while the host owns the memories must be ignored.
    en = 1'b1;
    start = 1'b1;
    repeat (16) tick();
    check("start_ignored_en", 32'(done), 32'd0);
    start = 1'b0;
    tick();

    // Maximum operands in word 0 only.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = (j == 0) ? 16'hFFFF : 16'h0;
        b_m[i][j] = (i == 0) ? 16'hFFFF : 16'h0;
      end
    load_matrices();
    run_start();
    sweep(4, 32'hFFFE_0001);
    release_start();

    // Random full-range operands, exercising accumulator wrap.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          a_m[i][j] = 16'($urandom());
          b_m[i][j] = 16'($urandom());
        end
      load_matrices();
      run_start();
      sweep(0, '0);
      release_start();
    end

    // Reset five cycles into a run aborts it and clears all results.
    start = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("abort_done", 32'(done), 32'd0);
    sweep(2, '0);
    run_start();
    sweep(0, '0);
    release_start();

    // Identity B: result equals A.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = 16'($urandom());
        b_m[i][j] = (i == j) ? 16'd1 : 16'd0;
      end
    load_matrices();
    run_start();
    sweep(3, '0);
    release_start();

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_mult_4x4.md
Name: matrix_mult_4x4

Overview:
- Self-contained 4x4 matrix-multiply engine with two on-chip 512x64 operand memories (A and B) and a 4x4 systolic MAC array.
- A host loads operands through a write port, pulses or holds start, waits for done, then reads the 16 results one at a time through a select-addressed output port.
- Intended as a standalone accelerator tile and benchmark block.

Parameters:
- DATA_W, 16, operand element width. Four elements are packed per 64-bit memory word.
- ADDR_W, 9, operand memory address width, giving 512 words per memory.
- OUT_W, 32, result element width.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- enable_writing_to_mem  in  1  1 = host owns both memory ports; 0 = engine owns them.
- we_a  in  1  host write enable for memory A; honoured only when enable_writing_to_mem=1.
- we_b  in  1  host write enable for memory B; honoured only when enable_writing_to_mem=1.
- data_pi  in  64  host write data (one packed word).
- addr_pi  in  9  host write address.
- start_mat_mul  in  1  level start request.
- done_mat_mul  out  1  result-valid flag.
- out_sel  in  9  result select, index = 4*i + j.
- data_out  out  32  selected result C[i][j].

Behaviour:
- Memories:
  - Two single-port synchronous RAMs, 512x64, instance names matrix_A_u and matrix_B_u, storage array named ram. Read latency is 1 cycle.
  - A word k holds column k of A: bits [16i+15:16i] = A[i][k].
  - B word k holds row k of B: bits [16j+15:16j] = B[k][j].
  - The engine reads words 0..3 only. Word 511 is reserved and must not be read.
  - Memory contents are not cleared by reset.
- Host writes: when enable_writing_to_mem=1 and we_a (or we_b) is high, data_pi is written to ram[addr_pi] of A (or B) at the clock edge.
- FSM states: IDLE, LOAD, COMPUTE, DONE.
- IDLE:
  - If start_mat_mul=1 and enable_writing_to_mem=0, clear all 16 accumulators and go to LOAD.
  - start_mat_mul is ignored while enable_writing_to_mem=1.
- LOAD / COMPUTE:
  - Read addresses 0,1,2,3 on consecutive cycles.
  - Row i of A enters the array skewed by i cycles; column j of B enters skewed by j cycles. The engine inserts zeros for the skew.
  - PE(i,j) computes acc += a*b. Each product is an unsigned 16x16 to 32-bit value; the accumulator is 32-bit and wraps modulo 2^32.
  - a values pass right and b values pass down with one register stage per PE.
- Timing: done_mat_mul rises exactly 12 cycles after the cycle in which start is accepted, and the FSM enters DONE.
- DONE:
  - done_mat_mul=1 and accumulators are frozen.
  - Stay in DONE while start_mat_mul=1; go to IDLE when it drops.
  - done_mat_mul falls on the cycle IDLE is entered. Results are retained until the next accepted start.
- Output: data_out = C[out_sel[3:0]] combinationally, available in any state. data_out = 0 when out_sel > 15.
- Reset:
  - FSM goes to IDLE; done_mat_mul=0; all accumulators and pipeline registers are 0; data_out reads 0.
  - Reset mid-computation aborts the run with no partial result preserved.
- Simultaneous events: start together with enable_writing_to_mem=1 means no start. Host writes during COMPUTE are ignored because enable_writing_to_mem must be 0 to run.

Decomposition:
- Package matmul_pkg holds: N=4, DATA_W, ADDR_W, OUT_W, the FSM state enum, and a helper function that extracts element i from a 64-bit word.
- Sub-module: ram_512x64 (synchronous single-port RAM, array ram), instantiated twice as matrix_A_u and matrix_B_u.
- The PE and skew registers stay inline via generate loops.

Test Plan:
- Load A words 0..3 = 0009_0005_0003_0008, 0001_0002_0003_0004, 0000_0001_0003_0006, 0005_0006_0007_0008. Load B words 0..3 = 0000_0003_0001_0001, 0003_0004_0001_0000, 0001_0003_0005_0003, 0002_0003_0006_0009. Hold start -> done within 12 cycles. C row0 = 98,90,82,34; row1 = 75,63,51,26; row2 = 62,48,44,19; row3 = 54,40,46,13.
- Continuing the previous run: sweep out_sel 0..15, then 16 and 511 -> data_out = C[i][j] per index; out-of-range selects give 0.
- Continuing the previous run: drop start -> done falls next cycle and results are retained. Raise start again -> identical results.
- Drive start with enable_writing_to_mem=1 -> no run, done stays 0. Write A word 0 = all 0xFFFF and B word 0 = all 0xFFFF, others 0, then run -> each C = 0xFFFE0001.
- Assert reset 5 cycles into a run -> done=0, data_out=0 for all selects. A fresh start then produces correct results.
- Set B = identity (words 0x0000_0000_0000_0001, 0x0000_0000_0001_0000, etc.) -> C equals A element-wise.
